fb_access_arbiter: RTL and testbench

- Owns the single port of the 8x8 LED frame buffer (64 entries x 4 bit) and shares it between three requesters, one access per cycle.
- Requesters: the scan reader that refreshes the matrix, the light-pen write path, and a bulk fill/clear engine.
- The clear engine is used by RST/ERASE-all; the fill engine uses the same path.
- Sits between the scan/pen logic and the RAM; reports the last written cell so the pen-feedback logic can track it.

---
 rtl/fb_access_arbiter_pkg.sv | 26 ++
 rtl/fb_access_arbiter_if.sv | 51 +++++
 rtl/fb_access_arbiter_fill_seq.sv | 70 +++++++
 rtl/fb_access_arbiter.sv | 108 ++++++++++
 tb/tb_fb_access_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fb_access_arbiter_pkg.sv
// Shared widths, FSM encodings and cell codes for the LED frame-buffer access arbiter.
// Address layout is {row, col} with row in the MSBs.
package fb_access_arbiter_pkg;

    localparam int unsigned FB_ROW_W  = 3;
    localparam int unsigned FB_COL_W  = 3;
    localparam int unsigned FB_DATA_W = 4;
    localparam int unsigned FB_ADDR_W = FB_ROW_W + FB_COL_W;

    localparam logic [FB_ADDR_W-1:0] FB_LAST_ADDR = '1;

    // {valid, g, r, spare}
    localparam logic [FB_DATA_W-1:0] CELL_ON  = 4'b1010;
    localparam logic [FB_DATA_W-1:0] CELL_OFF = 4'b1000;

    typedef enum logic {
        FB_IDLE = 1'b0,
        FB_FILL = 1'b1
    } fb_state_e;

    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [FB_ROW_W-1:0] row,
                                                     input logic [FB_COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/fb_access_arbiter_if.sv
// Requester and RAM-side signal bundle of the frame-buffer arbiter.
// The arbiter uses the slave view; requesters and the RAM model use the master view.
interface fb_access_arbiter_if
    import fb_access_arbiter_pkg::*;
#(
    parameter int unsigned ROW_W  = FB_ROW_W,
    parameter int unsigned COL_W  = FB_COL_W,
    parameter int unsigned DATA_W = FB_DATA_W
);
    localparam int unsigned ADDR_W = ROW_W + COL_W;

    logic              scan_req;
    logic [ROW_W-1:0]  scan_row;
    logic [COL_W-1:0]  scan_col;
    logic              scan_valid;
    logic [DATA_W-1:0] scan_data;

    logic              pen_req;
    logic [ROW_W-1:0]  pen_row;
    logic [COL_W-1:0]  pen_col;
    logic [DATA_W-1:0] pen_data;
    logic              pen_ack;

    logic              fill_start;
    logic [DATA_W-1:0] fill_data;
    logic              fill_busy;
    logic              fill_done;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [ROW_W-1:0]  row_d;
    logic [COL_W-1:0]  col_d;

    modport slave (
        input  scan_req, scan_row, scan_col, pen_req, pen_row, pen_col, pen_data,
        input  fill_start, fill_data, mem_rdata,
        output scan_valid, scan_data, pen_ack, fill_busy, fill_done,
        output mem_we, mem_addr, mem_wdata, row_d, col_d
    );

    modport master (
        output scan_req, scan_row, scan_col, pen_req, pen_row, pen_col, pen_data,
        output fill_start, fill_data, mem_rdata,
        input  scan_valid, scan_data, pen_ack, fill_busy, fill_done,
        input  mem_we, mem_addr, mem_wdata, row_d, col_d
    );

endinterface

// File: rtl/fb_access_arbiter_fill_seq.sv
// Bulk fill/clear sequencer: walks every frame-buffer address once with a latched value,
// stalling on cycles the scan reader owns the RAM port.
module fb_access_arbiter_fill_seq
    import fb_access_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = FB_ADDR_W,
    parameter int unsigned DATA_W = FB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_stall,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    fb_state_e         r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_done;
    logic              w_write;

    // No write in the reset cycle so an aborted fill stops cleanly.
    assign w_write = (r_state == FB_FILL) && !i_stall && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FB_IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                FB_IDLE: begin
                    if (i_start) begin
                        r_state <= FB_FILL;
                        r_cnt   <= '0;
                        r_data  <= i_data;
                    end
                end
                FB_FILL: begin
                    if (w_write) begin
                        if (r_cnt == LAST_ADDR) begin
                            r_state <= FB_IDLE;
                            r_cnt   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= FB_IDLE;
            endcase
        end
    end

    assign o_busy  = (r_state == FB_FILL);
    assign o_done  = r_done;
    assign o_we    = w_write;
    assign o_addr  = r_cnt;
    assign o_wdata = r_data;

endmodule

// File: rtl/fb_access_arbiter.sv
// Single-port frame-buffer arbiter: scan reads beat fill writes beat pen writes, one access
// per cycle. Tracks the last pen-written cell for the pen-feedback logic.
module fb_access_arbiter
    import fb_access_arbiter_pkg::*;
#(
    parameter int unsigned ROW_W  = FB_ROW_W,
    parameter int unsigned COL_W  = FB_COL_W,
    parameter int unsigned DATA_W = FB_DATA_W
) (
    input logic                clk,
    input logic                rst,
    fb_access_arbiter_if.slave bus
);

    localparam int unsigned ADDR_W = ROW_W + COL_W;

    logic              w_scan_rd;
    logic              w_pen_grant;
    logic              w_fill_busy;
    logic              w_fill_done;
    logic              w_fill_we;
    logic [ADDR_W-1:0] w_fill_addr;
    logic [DATA_W-1:0] w_fill_wdata;

    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    logic              r_armed;
    logic              r_scan_valid;
    logic [DATA_W-1:0] r_scan_hold;
    logic [ROW_W-1:0]  r_row_d;
    logic [COL_W-1:0]  r_col_d;

    fb_access_arbiter_fill_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fill_seq (
        .clk     (clk),
        .rst     (rst),
        .i_start (bus.fill_start),
        .i_data  (bus.fill_data),
        .i_stall (bus.scan_req),
        .o_busy  (w_fill_busy),
        .o_done  (w_fill_done),
        .o_we    (w_fill_we),
        .o_addr  (w_fill_addr),
        .o_wdata (w_fill_wdata)
    );

    assign w_scan_rd = bus.scan_req && !rst;

    // A fill_start in the same idle cycle takes precedence; the pen retries once fill ends.
    assign w_pen_grant = bus.pen_req && r_armed && !w_fill_busy && !bus.fill_start &&
                         !bus.scan_req && !rst;

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_scan_rd) begin
            w_mem_addr = {bus.scan_row, bus.scan_col};
        end else if (w_fill_we) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = w_fill_addr;
            w_mem_wdata = w_fill_wdata;
        end else if (w_pen_grant) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = {bus.pen_row, bus.pen_col};
            w_mem_wdata = bus.pen_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed      <= 1'b1;
            r_scan_valid <= 1'b0;
            r_scan_hold  <= '0;
            r_row_d      <= '0;
            r_col_d      <= '0;
        end else begin
            r_scan_valid <= w_scan_rd;
            if (r_scan_valid) begin
                r_scan_hold <= bus.mem_rdata;
            end
            // One write per pen_req assertion: re-arm only after the request is seen low.
            if (w_pen_grant) begin
                r_armed <= 1'b0;
                r_row_d <= bus.pen_row;
                r_col_d <= bus.pen_col;
            end else if (!bus.pen_req) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign bus.scan_valid = r_scan_valid;
    assign bus.scan_data  = r_scan_valid ? bus.mem_rdata : r_scan_hold;
    assign bus.pen_ack    = w_pen_grant;
    assign bus.fill_busy  = w_fill_busy;
    assign bus.fill_done  = w_fill_done;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_mem_wdata;
    assign bus.row_d      = r_row_d;
    assign bus.col_d      = r_col_d;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter: per-cycle vector table for scan/pen/reset cases,
// plus hand-written fill, fill-vs-pen and reset-mid-fill sequences against a simple RAM.
module tb_fb_access_arbiter;
    import fb_access_arbiter_pkg::*;

    typedef struct {
        int rst;  int scan; int srow; int scol;
        int pen;  int prow; int pcol; int pdata;
        int we;   int addr; int wdata; int ack;
        int sv;   int sdata; int rowd; int cold;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [FB_DATA_W-1:0] ram [64] = '{default: '0};

    fb_access_arbiter_if bus ();

    fb_access_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.scan_req = 1'b0; bus.scan_row = '0; bus.scan_col = '0;
        bus.pen_req = 1'b0; bus.pen_row = '0; bus.pen_col = '0; bus.pen_data = '0;
        bus.fill_start = 1'b0; bus.fill_data = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int r, sc, sr, scl, p, pr, pc, pd,
                                input int we, ad, wd, ak, sv, sd, rd, cd);
        vec_t v;
        v.rst = r; v.scan = sc; v.srow = sr; v.scol = scl;
        v.pen = p; v.prow = pr; v.pcol = pc; v.pdata = pd;
        v.we = we; v.addr = ad; v.wdata = wd; v.ack = ak;
        v.sv = sv; v.sdata = sd; v.rowd = rd; v.cold = cd;
        return v;
    endfunction

    vec_t vecs [25];

    initial begin
        int exp_addr;
        int k;
        int scans;

        //             rst sc sr sc pen pr pc pd  we ad wd ak sv sd rd cd
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 1, 2, 5, 10,  1, 21, 10, 1, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 1, 2, 5, 10,  0, 0, 0, 0, 0, 0, 2, 5);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 2, 5);
        vecs[4]  = mk(0, 1, 2, 5, 0, 0, 0, 0,   0, 21, 0, 0, 0, 0, 2, 5);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 10, 2, 5);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 10, 2, 5);
        vecs[7]  = mk(0, 0, 0, 0, 1, 7, 0, 10,  1, 56, 10, 1, 0, 10, 2, 5);
        vecs[8]  = mk(0, 0, 0, 0, 1, 7, 0, 10,  0, 0, 0, 0, 0, 10, 7, 0);
        vecs[9]  = mk(0, 0, 0, 0, 1, 7, 0, 10,  0, 0, 0, 0, 0, 10, 7, 0);
        vecs[10] = mk(0, 0, 0, 0, 1, 7, 0, 10,  0, 0, 0, 0, 0, 10, 7, 0);
        vecs[11] = mk(0, 0, 0, 0, 1, 7, 0, 10,  0, 0, 0, 0, 0, 10, 7, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 10, 7, 0);
        vecs[13] = mk(0, 0, 0, 0, 1, 7, 0, 5,   1, 56, 5, 1, 0, 10, 7, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 10, 7, 0);
        vecs[15] = mk(0, 0, 0, 0, 1, 3, 3, 3,   1, 27, 3, 1, 0, 10, 7, 0);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 10, 3, 3);
        vecs[17] = mk(0, 1, 3, 3, 1, 3, 3, 12,  0, 27, 0, 0, 0, 10, 3, 3);
        vecs[18] = mk(0, 0, 0, 0, 1, 3, 3, 12,  1, 27, 12, 1, 1, 3, 3, 3);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 3, 3, 3);
        vecs[20] = mk(0, 1, 3, 3, 0, 0, 0, 0,   0, 27, 0, 0, 0, 3, 3, 3);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 12, 3, 3);
        vecs[22] = mk(1, 0, 0, 0, 1, 1, 2, 6,   0, 0, 0, 0, 0, 12, 3, 3);
        vecs[23] = mk(0, 0, 0, 0, 1, 1, 2, 6,   1, 10, 6, 1, 0, 0, 0, 0);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 2);

        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            next_cycle();
            rst          = vecs[i].rst[0];
            bus.scan_req = vecs[i].scan[0];
            bus.scan_row = 3'(vecs[i].srow);
            bus.scan_col = 3'(vecs[i].scol);
            bus.pen_req  = vecs[i].pen[0];
            bus.pen_row  = 3'(vecs[i].prow);
            bus.pen_col  = 3'(vecs[i].pcol);
            bus.pen_data = 4'(vecs[i].pdata);
            @(negedge clk);
            chk($sformatf("v%0d.mem_we", i),     int'(bus.mem_we),     vecs[i].we);
            chk($sformatf("v%0d.mem_addr", i),   int'(bus.mem_addr),   vecs[i].addr);
            chk($sformatf("v%0d.mem_wdata", i),  int'(bus.mem_wdata),  vecs[i].wdata);
            chk($sformatf("v%0d.pen_ack", i),    int'(bus.pen_ack),    vecs[i].ack);
            chk($sformatf("v%0d.scan_valid", i), int'(bus.scan_valid), vecs[i].sv);
            chk($sformatf("v%0d.scan_data", i),  int'(bus.scan_data),  vecs[i].sdata);
            chk($sformatf("v%0d.row_d", i),      int'(bus.row_d),      vecs[i].rowd);
            chk($sformatf("v%0d.col_d", i),      int'(bus.col_d),      vecs[i].cold);
            chk($sformatf("v%0d.fill_busy", i),  int'(bus.fill_busy),  0);
            chk($sformatf("v%0d.fill_done", i),  int'(bus.fill_done),  0);
        end

        // Fill with CELL_OFF, scan every 4th cycle, pen waiting from cycle 5.
        next_cycle();
        idle_inputs();
        rst = 1'b0;
        bus.fill_start = 1'b1;
        bus.fill_data  = CELL_OFF;
        @(negedge clk);
        chk("fill.start_busy", int'(bus.fill_busy), 0);
        chk("fill.start_we", int'(bus.mem_we), 0);
        exp_addr = 0;
        scans = 0;
        k = 1;
        while (exp_addr < 64 && k < 300) begin
            next_cycle();
            idle_inputs();
            bus.scan_req = (k % 4 == 0);
            bus.scan_col = 3'd1;
            if (k >= 5) begin
                bus.pen_req = 1'b1; bus.pen_row = 3'd4; bus.pen_col = 3'd4; bus.pen_data = CELL_ON;
            end
            if (k == 10) begin
                bus.fill_start = 1'b1; bus.fill_data = CELL_ON;
            end
            @(negedge clk);
            chk($sformatf("fill.busy@%0d", k), int'(bus.fill_busy), 1);
            chk($sformatf("fill.pen_ack@%0d", k), int'(bus.pen_ack), 0);
            if (k % 4 == 0) begin
                scans++;
                chk($sformatf("fill.stall_we@%0d", k), int'(bus.mem_we), 0);
                chk($sformatf("fill.stall_addr@%0d", k), int'(bus.mem_addr), 1);
            end else begin
                chk($sformatf("fill.we@%0d", k), int'(bus.mem_we), 1);
                chk($sformatf("fill.addr@%0d", k), int'(bus.mem_addr), exp_addr);
                chk($sformatf("fill.wdata@%0d", k), int'(bus.mem_wdata), int'(CELL_OFF));
                exp_addr++;
            end
            k++;
        end
        chk("fill.writes", exp_addr, 64);
        chk("fill.duration", k - 1, 64 + scans);

        next_cycle();
        idle_inputs();
        bus.pen_req = 1'b1; bus.pen_row = 3'd4; bus.pen_col = 3'd4; bus.pen_data = CELL_ON;
        @(negedge clk);
        chk("fill.end_busy", int'(bus.fill_busy), 0);
        chk("fill.done", int'(bus.fill_done), 1);
        chk("fillpen.ack", int'(bus.pen_ack), 1);
        chk("fillpen.we", int'(bus.mem_we), 1);
        chk("fillpen.addr", int'(bus.mem_addr), int'(fb_addr(3'd4, 3'd4)));
        chk("fillpen.wdata", int'(bus.mem_wdata), int'(CELL_ON));
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("fill.done_once", int'(bus.fill_done), 0);
        chk("fillpen.row_d", int'(bus.row_d), 4);
        chk("fillpen.col_d", int'(bus.col_d), 4);
        chk("fill.ram0", int'(ram[0]), int'(CELL_OFF));
        chk("fill.ram_last", int'(ram[FB_LAST_ADDR]), int'(CELL_OFF));

        // Reset while the counter sits at 30.
        next_cycle();
        bus.fill_start = 1'b1;
        bus.fill_data  = CELL_ON;
        for (int c = 0; c < 30; c++) begin
            next_cycle();
            idle_inputs();
            @(negedge clk);
            chk($sformatf("rstfill.addr@%0d", c), int'(bus.mem_addr), c);
        end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rstfill.rst_we", int'(bus.mem_we), 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rstfill.busy", int'(bus.fill_busy), 0);
        chk("rstfill.done", int'(bus.fill_done), 0);
        chk("rstfill.we", int'(bus.mem_we), 0);
        chk("rstfill.addr", int'(bus.mem_addr), 0);
        chk("rstfill.row_d", int'(bus.row_d), 0);
        chk("rstfill.col_d", int'(bus.col_d), 0);
        chk("rstfill.scan_data", int'(bus.scan_data), 0);
        chk("rstfill.ram30", int'(ram[30]), int'(CELL_OFF));
        chk("rstfill.ram29", int'(ram[29]), int'(CELL_ON));
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("rstfill.no_done@%0d", c), int'(bus.fill_done), 0);
        end
        next_cycle();
        bus.fill_start = 1'b1;
        bus.fill_data  = CELL_OFF;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            idle_inputs();
            @(negedge clk);
            chk($sformatf("refill.busy@%0d", c), int'(bus.fill_busy), 1);
            chk($sformatf("refill.addr@%0d", c), int'(bus.mem_addr), c);
            chk($sformatf("refill.wdata@%0d", c), int'(bus.mem_wdata), int'(CELL_OFF));
        end

        next_cycle();
        rst = 1'b1;
        next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
